// File: rtl/yc_noc_defs.sv
// Shared NoC definitions: message kinds, the single-flit packet layout and sizing constants.
package yc_noc_defs;

    localparam int TAG_MAX_W = 4;
    localparam int COORD_W   = 4;

    typedef enum logic [2:0] {
        MSG_RD_REQ  = 3'd0,
        MSG_WR_REQ  = 3'd1,
        MSG_RD_RSP  = 3'd2,
        MSG_WR_RSP  = 3'd3,
        MSG_ERR_RSP = 3'd4
    } msg_kind_t;

    typedef struct packed {
        logic [COORD_W-1:0]   dst_x;
        logic [COORD_W-1:0]   dst_y;
        logic [COORD_W-1:0]   src_x;
        logic [COORD_W-1:0]   src_y;
        msg_kind_t            kind;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          addr;
        logic [31:0]          data;
    } flit_t;

    function automatic logic is_rsp_kind(input msg_kind_t kind);
        return (kind == MSG_RD_RSP) || (kind == MSG_WR_RSP) || (kind == MSG_ERR_RSP);
    endfunction

endpackage

// File: rtl/yc_mem_req_niu_tag_pool.sv
// Outstanding-transaction tag pool: free bitmap, lowest-free allocator, per-tag
// watchdog timers with lowest-expired selection, and the outstanding counter.
module yc_tag_pool #(
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 1024,
    parameter int TAG_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alloc,
    input  logic               free,
    input  logic [TAG_W-1:0]   free_tag,
    output logic               any_free,
    output logic [TAG_W-1:0]   alloc_tag,
    output logic [MAX_OUT-1:0] busy,
    output logic               expired_any,
    output logic [TAG_W-1:0]   expired_tag,
    output logic [TAG_W:0]     outstanding
);

    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LIM = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
    localparam logic [TAG_W:0]   CNT_ONE = (TAG_W + 1)'(1);

    logic [TMR_W-1:0] timer [MAX_OUT];

    // NOTE: every output is assigned a default before the loop, so no path
    // through this block leaves a value held and no latch is inferred.
    always_comb begin
        any_free    = 1'b0;
        alloc_tag   = '0;
        expired_any = 1'b0;
        expired_tag = '0;
        for (int i = MAX_OUT - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                any_free  = 1'b1;
                alloc_tag = TAG_W'(i);
            end
            if ((TIMEOUT > 0) && busy[i] && (timer[i] == TMR_LIM)) begin
                expired_any = 1'b1;
                expired_tag = TAG_W'(i);
            end
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge
    // values, so allocate and free of different tags compose in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            outstanding <= '0;
            // NOTE: the timers are per-tag control state, not a data memory,
            // so they are reset with the bitmap they qualify.
            for (int i = 0; i < MAX_OUT; i++) timer[i] <= '0;
        end else begin
            for (int i = 0; i < MAX_OUT; i++) begin
                if (alloc && (alloc_tag == TAG_W'(i))) begin
                    busy[i]  <= 1'b1;
                    timer[i] <= '0;
                end else if (free && (free_tag == TAG_W'(i))) begin
                    busy[i]  <= 1'b0;
                    timer[i] <= '0;
                end else if (busy[i] && (timer[i] != TMR_LIM)) begin
                    timer[i] <= timer[i] + TMR_ONE;
                end
            end
            case ({alloc, free})
                2'b10:   outstanding <= outstanding + CNT_ONE;
                2'b01:   outstanding <= outstanding - CNT_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/yc_mem_req_niu.sv
// Initiator NIU: core load/store requests become single-flit NoC requests and
// validated NoC responses (or watchdog expiries) become core responses.
module yc_mem_req_niu
    import yc_noc_defs::*;
#(
    parameter int SRC_X   = 0,
    parameter int SRC_Y   = 0,
    parameter int DST_X   = 1,
    parameter int DST_Y   = 0,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 1024,
    localparam int TAG_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [TAG_W-1:0] resp_tag,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic             tx_valid,
    output flit_t            tx_flit,
    input  logic             tx_ready,
    input  logic             rx_valid,
    input  flit_t            rx_flit,
    output logic             rx_ready,
    output logic [TAG_W:0]   outstanding,
    output logic [15:0]      drop_count
);

    logic               any_free;
    logic [TAG_W-1:0]   alloc_tag;
    logic [MAX_OUT-1:0] busy;
    logic               expired_any;
    logic [TAG_W-1:0]   expired_tag;
    logic               accept;
    logic               rx_hs;
    logic               rx_tag_busy;
    logic               rx_good;
    logic               to_retire;
    logic [TAG_W-1:0]   rx_tag;
    flit_t              req_flit;

    yc_tag_pool #(
        .MAX_OUT (MAX_OUT),
        .TIMEOUT (TIMEOUT),
        .TAG_W   (TAG_W)
    ) u_tag_pool (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc       (accept),
        .free        (rx_good || to_retire),
        .free_tag    (rx_good ? rx_tag : expired_tag),
        .any_free    (any_free),
        .alloc_tag   (alloc_tag),
        .busy        (busy),
        .expired_any (expired_any),
        .expired_tag (expired_tag),
        .outstanding (outstanding)
    );

    assign req_tag   = alloc_tag;
    assign req_ready = any_free && (!tx_valid || tx_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        req_flit       = '0;
        req_flit.dst_x = COORD_W'(DST_X);
        req_flit.dst_y = COORD_W'(DST_Y);
        req_flit.src_x = COORD_W'(SRC_X);
        req_flit.src_y = COORD_W'(SRC_Y);
        req_flit.kind  = req_we ? MSG_WR_REQ : MSG_RD_REQ;
        req_flit.tag   = TAG_MAX_W'(alloc_tag);
        req_flit.addr  = req_addr;
        req_flit.data  = req_we ? req_wdata : 32'h0;
    end

    // The response register and the rx port share one "loadable" condition.
    assign rx_ready = !resp_valid || resp_ready;
    assign rx_hs    = rx_valid && rx_ready;
    assign rx_tag   = rx_flit.tag[TAG_W-1:0];

    // Full-width tag match so tags beyond MAX_OUT never alias a live slot.
    always_comb begin
        rx_tag_busy = 1'b0;
        for (int i = 0; i < MAX_OUT; i++) begin
            if (busy[i] && (rx_flit.tag == TAG_MAX_W'(i))) rx_tag_busy = 1'b1;
        end
    end

    assign rx_good   = rx_hs && is_rsp_kind(rx_flit.kind) && rx_tag_busy &&
                       (rx_flit.dst_x == COORD_W'(SRC_X)) &&
                       (rx_flit.dst_y == COORD_W'(SRC_Y));
    assign to_retire = rx_ready && !rx_good && expired_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid <= 1'b0;
            tx_flit  <= '0;
        end else if (accept) begin
            tx_valid <= 1'b1;
            tx_flit  <= req_flit;
        end else if (tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_tag   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (rx_good) begin
                resp_valid <= 1'b1;
                resp_tag   <= rx_tag;
                resp_rdata <= (rx_flit.kind == MSG_RD_RSP) ? rx_flit.data : 32'h0;
                resp_err   <= (rx_flit.kind == MSG_ERR_RSP);
            end else if (to_retire) begin
                resp_valid <= 1'b1;
                resp_tag   <= expired_tag;
                resp_rdata <= '0;
                resp_err   <= 1'b1;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
            if (rx_hs && !rx_good && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    // Response flits carry fields this initiator has no use for.
    logic unused_rx_bits;
    assign unused_rx_bits = ^{rx_flit.src_x, rx_flit.src_y, rx_flit.addr};

endmodule
